timer_share_sequencer: RTL and testbench

- Shares one 16-bit-bus interval timer slave between NUM_REQ requesters, for example per-core timeout requests in the multicore system.
- Arbitrates round-robin among the requesters and grants one one-shot timeout at a time.
- Programs the timer through its register map with a fixed write sequence, waits for its irq, then clears the status and returns a done pulse to the owner.
- Sits between the per-core request logic and the timer's s1 slave port, as its only master.

---
 rtl/timer_share_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_timer_share_sequencer.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_share_sequencer.sv
// Round-robin owner of one shared interval timer: programs a one-shot timeout per grant, waits for irq or cancel.
// Optional build macro TIMER_SHARE_SEQ_SNAPSHOT_EN reads the remaining count back on cancel (cancel_remaining).
module timer_share_sequencer #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_period,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_cancel,
  output logic [NUM_REQ-1:0]      done,
  output logic [NUM_REQ-1:0]      cancelled,
  output logic                    busy,
  output logic [IDX_W-1:0]        owner,
  output logic [2:0]              tmr_address,
  output logic                    tmr_chipselect,
  output logic                    tmr_write_n,
  output logic [15:0]             tmr_writedata,
  input  logic [15:0]             tmr_readdata,
  input  logic                    tmr_irq
`ifdef TIMER_SHARE_SEQ_SNAPSHOT_EN
  ,
  output logic [31:0]             cancel_remaining
`endif
);

  localparam int unsigned PER_W  = 32;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 16;

  localparam logic [ADDR_W-1:0] REG_STATUS  = 3'd0;
  localparam logic [ADDR_W-1:0] REG_CONTROL = 3'd1;
  localparam logic [ADDR_W-1:0] REG_PER_L   = 3'd2;
  localparam logic [ADDR_W-1:0] REG_PER_H   = 3'd3;
  localparam logic [ADDR_W-1:0] REG_SNAP_L  = 3'd4;
  localparam logic [ADDR_W-1:0] REG_SNAP_H  = 3'd5;
  localparam logic [DATA_W-1:0] CTRL_STOP   = 16'h0008;
  localparam logic [DATA_W-1:0] CTRL_GO     = 16'h0005;

  typedef enum logic [3:0] {
    IDLE, WR_STOP, WR_CLR0, WR_PL, WR_PH, WR_GO, WAIT_IRQ, WR_KILL,
    WR_SNAP, RD_SL, RD_SH, RD_SH_HOLD, WR_ACK, FINISH
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PER_W-1:0]     period_q, period_d;
  logic                 cancel_q, cancel_d;
  logic [NUM_REQ-1:0]   req_ready_d, done_d, cancelled_d;
  logic                 busy_d;
  logic [IDX_W-1:0]     owner_d;
  logic                 cs_d, wr_n_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [DATA_W-1:0]    wdata_d;
  logic [IDX_W-1:0]     winner, cand, next_ptr;
  logic                 found;

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    winner = rr_ptr_q;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
    next_ptr = IDX_W'((32'(winner) + 32'd1) % NUM_REQ);
  end

  // Next state, plus the bus access each state performs (registered, so it appears one cycle later).
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    period_d    = period_q;
    cancel_d    = cancel_q;
    req_ready_d = '0;
    done_d      = '0;
    cancelled_d = '0;
    busy_d      = busy;
    owner_d     = owner;
    cs_d        = 1'b0;
    wr_n_d      = 1'b1;
    addr_d      = '0;
    wdata_d     = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready_d = NUM_REQ'(1) << winner;
          owner_d     = winner;
          rr_ptr_d    = next_ptr;
          period_d    = req_period[32*winner +: 32];
          busy_d      = 1'b1;
          cancel_d    = 1'b0;
          state_d     = WR_STOP;
        end
      end
      WR_STOP: begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = REG_CONTROL; wdata_d = CTRL_STOP; state_d = WR_CLR0; end
      WR_CLR0: begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = REG_STATUS; state_d = WR_PL; end
      WR_PL:   begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = REG_PER_L; wdata_d = period_q[15:0]; state_d = WR_PH; end
      WR_PH:   begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = REG_PER_H; wdata_d = period_q[31:16]; state_d = WR_GO; end
      WR_GO:   begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = REG_CONTROL; wdata_d = CTRL_GO; state_d = WAIT_IRQ; end
      WAIT_IRQ: begin
        // irq takes priority over a same-cycle cancel
        if (tmr_irq) begin
          cancel_d = 1'b0;
          state_d  = WR_ACK;
        end else if (req_cancel[owner]) begin
          cancel_d = 1'b1;
          state_d  = WR_KILL;
        end
      end
      WR_KILL: begin
        cs_d = 1'b1; wr_n_d = 1'b0; addr_d = REG_CONTROL; wdata_d = CTRL_STOP;
`ifdef TIMER_SHARE_SEQ_SNAPSHOT_EN
        state_d = WR_SNAP;
`else
        state_d = WR_ACK;
`endif
      end
`ifdef TIMER_SHARE_SEQ_SNAPSHOT_EN
      WR_SNAP:    begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = REG_SNAP_L; state_d = RD_SL; end
      RD_SL:      begin cs_d = 1'b1; addr_d = REG_SNAP_L; state_d = RD_SH; end
      RD_SH:      begin cs_d = 1'b1; addr_d = REG_SNAP_H; state_d = RD_SH_HOLD; end
      RD_SH_HOLD: state_d = WR_ACK;
`endif
      WR_ACK:  begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = REG_STATUS; state_d = FINISH; end
      FINISH: begin
        if (cancel_q) cancelled_d = NUM_REQ'(1) << owner;
        else          done_d      = NUM_REQ'(1) << owner;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      period_q       <= '0;
      cancel_q       <= 1'b0;
      req_ready      <= '0;
      done           <= '0;
      cancelled      <= '0;
      busy           <= 1'b0;
      owner          <= '0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= '0;
      tmr_writedata  <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      period_q       <= period_d;
      cancel_q       <= cancel_d;
      req_ready      <= req_ready_d;
      done           <= done_d;
      cancelled      <= cancelled_d;
      busy           <= busy_d;
      owner          <= owner_d;
      tmr_chipselect <= cs_d;
      tmr_write_n    <= wr_n_d;
      tmr_address    <= addr_d;
      tmr_writedata  <= wdata_d;
    end
  end

`ifdef TIMER_SHARE_SEQ_SNAPSHOT_EN
  logic             rd_pend_q, rd_hi_q;
  logic [PER_W-1:0] snap_q;

  // Read data returns the cycle after a read is on the bus; capture it by the address that was read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend_q        <= 1'b0;
      rd_hi_q          <= 1'b0;
      snap_q           <= '0;
      cancel_remaining <= '0;
    end else begin
      rd_pend_q <= tmr_chipselect & tmr_write_n;
      rd_hi_q   <= (tmr_address == REG_SNAP_H);
      if (rd_pend_q) begin
        if (rd_hi_q) snap_q[31:16] <= tmr_readdata;
        else         snap_q[15:0]  <= tmr_readdata;
      end
      if (state_q == FINISH && cancel_q) cancel_remaining <= snap_q;
    end
  end
`else
  logic unused_readdata;
  assign unused_readdata = ^tmr_readdata;
`endif

endmodule

// File: tb/tb_timer_share_sequencer.sv
// Bench for timer_share_sequencer: stub timer slave, bus monitor, and a transaction-level reference model.
`timescale 1ns/1ps
module tb_timer_share_sequencer;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_REQ-1:0]     req_valid, req_cancel, req_ready, done, cancelled;
  logic [32*NUM_REQ-1:0]  req_period;
  logic                   busy;
  logic [IDX_W-1:0]       owner;
  logic [2:0]             tmr_address;
  logic                   tmr_chipselect, tmr_write_n, tmr_irq;
  logic [15:0]            tmr_writedata, tmr_readdata;
`ifdef TIMER_SHARE_SEQ_SNAPSHOT_EN
  logic [31:0]            cancel_remaining;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {logic wr; logic [2:0] addr; logic [15:0] data;} acc_t;
  acc_t bus_q[$];
  acc_t exp_q[$];

  timer_share_sequencer #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_period(req_period),
    .req_ready(req_ready), .req_cancel(req_cancel), .done(done), .cancelled(cancelled),
    .busy(busy), .owner(owner), .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata), .tmr_readdata(tmr_readdata),
    .tmr_irq(tmr_irq)
`ifdef TIMER_SHARE_SEQ_SNAPSHOT_EN
    , .cancel_remaining(cancel_remaining)
`endif
  );

  always #5 clk = ~clk;

  // Stub one-shot timer slave with registered read data.
  logic [31:0] t_period, t_count, t_snap, snap_force_val;
  logic        t_run, t_to, irq_force, snap_force;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t_period <= '0; t_count <= '0; t_snap <= '0; t_run <= 1'b0; t_to <= 1'b0; tmr_readdata <= '0;
    end else begin
      if (t_run) begin
        if (t_count == 0) begin t_to <= 1'b1; t_run <= 1'b0; end
        else t_count <= t_count - 1;
      end
      if (tmr_chipselect && !tmr_write_n) begin
        case (tmr_address)
          3'd0: t_to <= 1'b0;
          3'd1: begin
            if (tmr_writedata[3]) t_run <= 1'b0;
            if (tmr_writedata[2]) begin t_run <= 1'b1; t_count <= t_period; end
          end
          3'd2: t_period[15:0]  <= tmr_writedata;
          3'd3: t_period[31:16] <= tmr_writedata;
          3'd4: t_snap <= snap_force ? snap_force_val : t_count;
          default: ;
        endcase
      end
      if (tmr_chipselect && tmr_write_n)
        tmr_readdata <= (tmr_address == 3'd4) ? t_snap[15:0] :
                        (tmr_address == 3'd5) ? t_snap[31:16] : 16'h0;
    end
  end
  assign tmr_irq = t_to | irq_force;

  // Bus monitor: one entry per access cycle.
  always @(negedge clk) begin
    acc_t a;
    if (!reset && tmr_chipselect) begin
      a.wr   = !tmr_write_n;
      a.addr = tmr_address;
      a.data = tmr_write_n ? 16'h0 : tmr_writedata;
      bus_q.push_back(a);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; req_cancel = '0; irq_force = 1'b0; snap_force = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    bus_q.delete();
    tick();
  endtask

  function automatic acc_t mk(logic wr, logic [2:0] a, logic [15:0] d);
    acc_t r;
    r.wr = wr; r.addr = a; r.data = d;
    return r;
  endfunction

  // Reference trace for one grant: program, optional cancel path, status clear.
  task automatic build_exp(input logic [31:0] per, input bit canc);
    exp_q.delete();
    exp_q.push_back(mk(1'b1, 3'd1, 16'h0008));
    exp_q.push_back(mk(1'b1, 3'd0, 16'h0000));
    exp_q.push_back(mk(1'b1, 3'd2, per[15:0]));
    exp_q.push_back(mk(1'b1, 3'd3, per[31:16]));
    exp_q.push_back(mk(1'b1, 3'd1, 16'h0005));
    if (canc) begin
      exp_q.push_back(mk(1'b1, 3'd1, 16'h0008));
`ifdef TIMER_SHARE_SEQ_SNAPSHOT_EN
      exp_q.push_back(mk(1'b1, 3'd4, 16'h0000));
      exp_q.push_back(mk(1'b0, 3'd4, 16'h0000));
      exp_q.push_back(mk(1'b0, 3'd5, 16'h0000));
`endif
    end
    exp_q.push_back(mk(1'b1, 3'd0, 16'h0000));
  endtask

  function automatic bit trace_ok();
    if (bus_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (bus_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_grant(output int idx, output bit ok);
    ok = 1'b0; idx = -1;
    for (int k = 0; k < 20 && !ok; k++) begin
      tick();
      if (req_ready != '0) begin
        ok = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) idx = i;
      end
    end
  endtask

  task automatic wait_wait_irq(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      if (bus_q.size() >= 5) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic wait_finish(output logic [3:0] d, output logic [3:0] c, output bit ok);
    ok = 1'b0; d = '0; c = '0;
    for (int k = 0; k < 500 && !ok; k++) begin
      tick();
      if ((done | cancelled) != '0) begin ok = 1'b1; d = done; c = cancelled; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; req_cancel = '0; req_period = '0; irq_force = 1'b0;
    snap_force = 1'b0; snap_force_val = '0;
    tick();
    n_checks++;
    if ({req_ready, done, cancelled} !== 12'h000) $display("FAIL reset_pulses: got %h expected 000", {req_ready, done, cancelled});
    else n_pass++;
    n_checks++;
    if ({busy, owner} !== 3'b000) $display("FAIL reset_busy_owner: got %b expected 000", {busy, owner});
    else n_pass++;
    n_checks++;
    if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b0, 1'b1, 3'd0, 16'h0})
      $display("FAIL reset_bus: got cs=%b wn=%b a=%0d d=%h expected cs=0 wn=1 a=0 d=0000",
               tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
    else n_pass++;
`ifdef TIMER_SHARE_SEQ_SNAPSHOT_EN
    n_checks++;
    if (cancel_remaining !== 32'h0) $display("FAIL reset_remaining: got %h expected 0", cancel_remaining);
    else n_pass++;
`endif
    do_reset();
  endtask

  task automatic test_single();
    logic [2:0]  ea [5] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd1};
    logic [15:0] ed [5] = '{16'h0008, 16'h0000, 16'h0010, 16'h0000, 16'h0005};
    int k;
    req_period[31:0] = 32'h0000_0010;
    req_valid = 4'b0001;
    tick();
    n_checks++;
    if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b expected 0001", req_ready);
    else n_pass++;
    req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b1, 1'b0, ea[i], ed[i]})
        $display("FAIL single_write%0d: got cs=%b wn=%b a=%0d d=%h expected cs=1 wn=0 a=%0d d=%h",
                 i, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, ea[i], ed[i]);
      else n_pass++;
    end
    tick();
    n_checks++;
    if ({tmr_chipselect, busy} !== 2'b01) $display("FAIL single_wait_idle: got cs,busy=%b expected 01", {tmr_chipselect, busy});
    else n_pass++;
    k = 0;
    while (!tmr_irq && k < 100) begin tick(); k++; end
    n_checks++;
    if (tmr_irq !== 1'b1) $display("FAIL single_irq: got irq=%b expected 1", tmr_irq);
    else n_pass++;
    tick(); tick();
    n_checks++;
    if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b1, 1'b0, 3'd0, 16'h0})
      $display("FAIL single_ack: got cs=%b wn=%b a=%0d d=%h expected cs=1 wn=0 a=0 d=0000",
               tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
    else n_pass++;
    tick();
    n_checks++;
    if ({done, cancelled, busy} !== {4'b0001, 4'b0000, 1'b0})
      $display("FAIL single_done: got done=%b canc=%b busy=%b expected 0001 0000 0", done, cancelled, busy);
    else n_pass++;
    tick();
    n_checks++;
    if (done !== 4'b0000) $display("FAIL single_done_pulse: got %b expected 0000", done);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int idx, expw;
    bit ok;
    logic [3:0] d, c;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) req_period[32*i +: 32] = 32'd2;
    req_valid = 4'b1111;
    expw = 0;
    for (int n = 0; n < 5; n++) begin
      wait_grant(idx, ok);
      n_checks++;
      if (!ok || idx !== expw) $display("FAIL rr_grant%0d: got %0d expected %0d", n, idx, expw);
      else n_pass++;
      wait_finish(d, c, ok);
      n_checks++;
      if (!ok || d !== 4'(1 << expw)) $display("FAIL rr_done%0d: got %b expected %b", n, d, 4'(1 << expw));
      else n_pass++;
      expw = (expw + 1) % NUM_REQ;
    end
    req_valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_cancel();
    int idx;
    bit ok;
    logic [3:0] d, c;
    logic [31:0] per = 32'h00FF_0000;
    do_reset();
    snap_force = 1'b1; snap_force_val = 32'h0001_2345;
    req_period[32*2 +: 32] = per;
    req_valid = 4'b0100;
    wait_grant(idx, ok);
    n_checks++;
    if (!ok || idx !== 2 || owner !== 2'd2) $display("FAIL cancel_grant: got idx=%0d owner=%0d expected 2", idx, owner);
    else n_pass++;
    req_valid = '0;
    wait_wait_irq(ok);
    req_cancel = 4'b0010;
    repeat (3) tick();
    req_cancel = '0;
    n_checks++;
    if (!ok || busy !== 1'b1 || cancelled !== 4'b0 || bus_q.size() != 5)
      $display("FAIL cancel_nonowner: got busy=%b canc=%b accesses=%0d expected 1 0000 5", busy, cancelled, bus_q.size());
    else n_pass++;
    req_cancel = 4'b0100;
    tick();
    req_cancel = '0;
    wait_finish(d, c, ok);
    n_checks++;
    if (!ok || c !== 4'b0100 || d !== 4'b0000) $display("FAIL cancel_pulse: got canc=%b done=%b expected 0100 0000", c, d);
    else n_pass++;
`ifdef TIMER_SHARE_SEQ_SNAPSHOT_EN
    n_checks++;
    if (cancel_remaining !== 32'h0001_2345) $display("FAIL cancel_remaining: got %h expected 00012345", cancel_remaining);
    else n_pass++;
`endif
    build_exp(per, 1'b1);
    n_checks++;
    if (trace_ok() !== 1'b1) $display("FAIL cancel_trace: got %0d accesses expected %0d matching", bus_q.size(), exp_q.size());
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL cancel_busy: got %b expected 0", busy);
    else n_pass++;
    snap_force = 1'b0;
  endtask

  task automatic test_irq_cancel_same();
    int idx;
    bit ok;
    logic [3:0] d, c;
    logic [31:0] per = 32'h00FF_0000;
    req_period[31:0] = per;
    bus_q.delete();
    req_valid = 4'b0001;
    wait_grant(idx, ok);
    req_valid = '0;
    wait_wait_irq(ok);
    irq_force = 1'b1; req_cancel = 4'b0001;
    tick();
    irq_force = 1'b0; req_cancel = '0;
    wait_finish(d, c, ok);
    n_checks++;
    if (!ok || d !== 4'b0001 || c !== 4'b0000) $display("FAIL same_pulse: got done=%b canc=%b expected 0001 0000", d, c);
    else n_pass++;
    build_exp(per, 1'b0);
    n_checks++;
    if (trace_ok() !== 1'b1) $display("FAIL same_trace: got %0d accesses expected %0d matching", bus_q.size(), exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int idx;
    bit ok;
    logic [3:0] d, c;
    do_reset();
    req_period[31:0]  = 32'h1234_0007;
    req_period[63:32] = 32'd5;
    req_valid = 4'b0001;
    repeat (4) tick();
    req_valid = '0;
    n_checks++;
    if ({tmr_address, tmr_writedata} !== {3'd2, 16'h0007}) $display("FAIL mid_pl: got a=%0d d=%h expected 2 0007", tmr_address, tmr_writedata);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, done, cancelled, busy, owner, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !==
        {12'h000, 1'b0, 2'd0, 1'b0, 1'b1, 3'd0, 16'h0})
      $display("FAIL mid_reset: got busy=%b owner=%0d cs=%b wn=%b a=%0d d=%h expected 0 0 0 1 0 0000",
               busy, owner, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
    else n_pass++;
    tick();
    reset = 1'b0;
    bus_q.delete();
    req_valid = 4'b0010;
    wait_grant(idx, ok);
    n_checks++;
    if (!ok || idx !== 1 || owner !== 2'd1) $display("FAIL mid_grant: got idx=%0d owner=%0d expected 1", idx, owner);
    else n_pass++;
    req_valid = '0;
    tick();
    n_checks++;
    if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b1, 1'b0, 3'd1, 16'h0008})
      $display("FAIL mid_stop: got cs=%b wn=%b a=%0d d=%h expected 1 0 1 0008", tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
    else n_pass++;
    wait_finish(d, c, ok);
    n_checks++;
    if (!ok || d !== 4'b0010) $display("FAIL mid_done: got %b expected 0010", d);
    else n_pass++;
    build_exp(32'd5, 1'b0);
    n_checks++;
    if (trace_ok() !== 1'b1) $display("FAIL mid_trace: got %0d accesses expected %0d matching", bus_q.size(), exp_q.size());
    else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0]  pending, newb, d, c, expd, expc;
    bit          plan [NUM_REQ];
    logic [31:0] per [NUM_REQ];
    int          ptr, w, expw;
    bit          ok;
    do_reset();
    pending = '0;
    ptr = 0;
    for (int it = 0; it < 12; it++) begin
      newb = 4'($urandom_range(0, 15));
      if ((pending | newb) == '0) newb = 4'(1 << $urandom_range(0, 3));
      for (int i = 0; i < NUM_REQ; i++) begin
        if (newb[i] && !pending[i]) begin
          plan[i] = ($urandom_range(0, 2) == 0);
          per[i]  = plan[i] ? (32'h0001_0000 | 32'($urandom)) : 32'($urandom_range(0, 24));
          req_period[32*i +: 32] = per[i];
        end
      end
      pending = pending | newb;
      req_valid = pending;
      expw = -1;
      for (int k = 0; k < NUM_REQ; k++) if (expw < 0 && pending[(ptr + k) % NUM_REQ]) expw = (ptr + k) % NUM_REQ;
      bus_q.delete();
      wait_grant(w, ok);
      n_checks++;
      if (!ok || w !== expw) begin
        $display("FAIL rand_grant%0d: got %0d expected %0d", it, w, expw);
        break;
      end else n_pass++;
      pending[w] = 1'b0;
      req_valid = pending;
      ptr = (w + 1) % NUM_REQ;
      wait_wait_irq(ok);
      req_cancel = 4'(1 << ((w + 1 + $urandom_range(0, 2)) % NUM_REQ));
      tick();
      req_cancel = '0;
      if (plan[w]) begin
        repeat ($urandom_range(0, 3)) tick();
        req_cancel = 4'(1 << w);
        tick();
        req_cancel = '0;
      end
      wait_finish(d, c, ok);
      expd = plan[w] ? 4'b0000 : 4'(1 << w);
      expc = plan[w] ? 4'(1 << w) : 4'b0000;
      n_checks++;
      if (!ok || d !== expd || c !== expc) $display("FAIL rand_end%0d: got done=%b canc=%b expected %b %b", it, d, c, expd, expc);
      else n_pass++;
      build_exp(per[w], plan[w]);
      n_checks++;
      if (trace_ok() !== 1'b1) $display("FAIL rand_trace%0d: got %0d accesses expected %0d matching", it, bus_q.size(), exp_q.size());
      else n_pass++;
    end
    req_valid = '0;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_cancel();
    test_irq_cancel_same();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
